// File: rtl/scan_mux_pkg.sv
// Shared types and helpers for the scan_mux display-source selector.
package scan_mux_pkg;

   typedef enum logic {ST_MANUAL, ST_SCAN} state_e;

   // Out-of-range manual selects land on the last real channel.
   function automatic int unsigned clamp_ch(input int unsigned sel,
                                            input int unsigned channels);
      return (sel >= channels) ? channels - 1 : sel;
   endfunction

endpackage

// File: rtl/scan_mux_dwell_counter.sv
// Dwell-time counter: tc_o pulses on the last cycle of each DWELL-cycle window while enabled.
module dwell_counter #(
   parameter int unsigned DWELL = 50_000_000
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);

   // DWELL=1 keeps a 1-bit counter pinned at 0, so tc_o degenerates to en_i.
   localparam int unsigned CW = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [CW-1:0] LastCnt = CW'(DWELL - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = (cnt_q == LastCnt) ? '0 : cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc_o = en_i && (cnt_q == LastCnt);

endmodule

// File: rtl/scan_mux.sv
// Registered CHANNELS-to-1 word selector with manual select and round-robin auto-scan modes.
module scan_mux
   import scan_mux_pkg::*;
#(
   parameter int unsigned WIDTH    = 16,
   parameter int unsigned CHANNELS = 4,
   parameter int unsigned DWELL    = 50_000_000,
   localparam int unsigned SW      = $clog2(CHANNELS)
) (
   input  logic                      clk_i,
   input  logic                      reset_i,
   input  logic [CHANNELS*WIDTH-1:0] din_i,
   input  logic [SW-1:0]             sel_i,
   input  logic                      scan_en_i,
   input  logic                      hold_i,
   output logic [WIDTH-1:0]          dout_o,
   output logic [SW-1:0]             ch_o,
   output logic                      strobe_o
);

   localparam logic [SW-1:0] LastCh = SW'(CHANNELS - 1);

   state_e            state_q, state_d;
   logic [SW-1:0]     ch_q, ch_d;
   logic [WIDTH-1:0]  dout_q, dout_d;
   logic              strobe_q, strobe_d;
   logic [SW-1:0]     sel_clamped;
   logic              cnt_clr, cnt_en, cnt_tc;

   assign sel_clamped = SW'(clamp_ch(32'(sel_i), CHANNELS));

   // Count only while settled in scan mode; any manual cycle or mode exit restarts the dwell.
   assign cnt_en  = (state_q == ST_SCAN) && scan_en_i && !hold_i;
   assign cnt_clr = (state_q == ST_MANUAL) || !scan_en_i;

   dwell_counter #(
      .DWELL (DWELL)
   ) u_dwell (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .clr_i   (cnt_clr),
      .en_i    (cnt_en),
      .tc_o    (cnt_tc)
   );

   always_comb begin
      state_d = state_q;
      ch_d    = ch_q;
      unique case (state_q)
         ST_MANUAL: begin
            if (scan_en_i) begin
               state_d = ST_SCAN;
            end else begin
               ch_d = sel_clamped;
            end
         end
         ST_SCAN: begin
            if (!scan_en_i) begin
               state_d = ST_MANUAL;
               ch_d    = sel_clamped;
            end else if (cnt_tc) begin
               ch_d = (ch_q == LastCh) ? '0 : ch_q + SW'(1);
            end
         end
         default: state_d = ST_MANUAL;
      endcase
   end

   // Output word tracks live din of the channel being latched this edge.
   always_comb begin
      dout_d = '0;
      for (int unsigned k = 0; k < CHANNELS; k++) begin
         if (ch_d == SW'(k)) begin
            dout_d = din_i[k*WIDTH +: WIDTH];
         end
      end
   end

   assign strobe_d = (ch_d != ch_q);

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q  <= ST_MANUAL;
         ch_q     <= '0;
         dout_q   <= '0;
         strobe_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         ch_q     <= ch_d;
         dout_q   <= dout_d;
         strobe_q <= strobe_d;
      end
   end

   assign dout_o   = dout_q;
   assign ch_o     = ch_q;
   assign strobe_o = strobe_q;

endmodule

// File: tb/tb_scan_mux.sv
// Directed bench for scan_mux: a 4x16 DWELL=3 instance and a 3x8 DWELL=2 instance.
module tb_scan_mux;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   // Instance A: WIDTH=16, CHANNELS=4, DWELL=3
   logic [63:0] a_din;
   logic [1:0]  a_sel;
   logic        a_scan_en, a_hold;
   logic [15:0] a_dout;
   logic [1:0]  a_ch;
   logic        a_strobe;

   // Instance B: WIDTH=8, CHANNELS=3, DWELL=2
   logic [23:0] b_din;
   logic [1:0]  b_sel;
   logic        b_scan_en, b_hold;
   logic [7:0]  b_dout;
   logic [1:0]  b_ch;
   logic        b_strobe;

   int n_checks = 0;
   int n_pass   = 0;

   scan_mux #(.WIDTH(16), .CHANNELS(4), .DWELL(3)) dut_a (
      .clk_i(clk), .reset_i(reset), .din_i(a_din), .sel_i(a_sel), .scan_en_i(a_scan_en),
      .hold_i(a_hold), .dout_o(a_dout), .ch_o(a_ch), .strobe_o(a_strobe)
   );

   scan_mux #(.WIDTH(8), .CHANNELS(3), .DWELL(2)) dut_b (
      .clk_i(clk), .reset_i(reset), .din_i(b_din), .sel_i(b_sel), .scan_en_i(b_scan_en),
      .hold_i(b_hold), .dout_o(b_dout), .ch_o(b_ch), .strobe_o(b_strobe)
   );

   localparam logic [63:0] ADin = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA};

   function automatic logic [15:0] a_word(input int k);
      case (k)
         0: return 16'hAAAA;
         1: return 16'hBBBB;
         2: return 16'hCCCC;
         default: return 16'hDDDD;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         a_din = {$urandom, $urandom}; a_sel = 2'($urandom);
         a_scan_en = 1'($urandom); a_hold = 1'($urandom);
         b_din = 24'($urandom); b_sel = 2'($urandom);
         b_scan_en = 1'($urandom); b_hold = 1'($urandom);
         tick();
         n_checks++;
         if ({a_ch, a_dout, a_strobe} !== 19'd0)
            $display("FAIL reset_a[%0d]: ch=%0d dout=%h strobe=%b, want 0/0000/0",
                     i, a_ch, a_dout, a_strobe);
         else n_pass++;
         n_checks++;
         if ({b_ch, b_dout, b_strobe} !== 11'd0)
            $display("FAIL reset_b[%0d]: ch=%0d dout=%h strobe=%b, want 0/00/0",
                     i, b_ch, b_dout, b_strobe);
         else n_pass++;
      end
      reset = 1'b0;
      a_din = ADin; a_sel = 2'd0; a_scan_en = 1'b0; a_hold = 1'b0;
      b_din = {8'h33, 8'h22, 8'h11}; b_sel = 2'd0; b_scan_en = 1'b0; b_hold = 1'b0;
      tick();
      n_checks++;
      if ({a_ch, a_dout, a_strobe} !== {2'd0, 16'hAAAA, 1'b0})
         $display("FAIL reset_release: ch=%0d dout=%h strobe=%b, want 0/aaaa/0",
                  a_ch, a_dout, a_strobe);
      else n_pass++;
   endtask

   task automatic test_manual();
      a_sel = 2'd2;
      tick();
      n_checks++;
      if ({a_ch, a_dout, a_strobe} !== {2'd2, 16'hCCCC, 1'b1})
         $display("FAIL manual_sel2: ch=%0d dout=%h strobe=%b, want 2/cccc/1",
                  a_ch, a_dout, a_strobe);
      else n_pass++;
      tick();
      n_checks++;
      if ({a_ch, a_dout, a_strobe} !== {2'd2, 16'hCCCC, 1'b0})
         $display("FAIL manual_steady: ch=%0d dout=%h strobe=%b, want 2/cccc/0",
                  a_ch, a_dout, a_strobe);
      else n_pass++;
      a_din[47:32] = 16'h1234;
      tick();
      n_checks++;
      if ({a_ch, a_dout, a_strobe} !== {2'd2, 16'h1234, 1'b0})
         $display("FAIL manual_live_din: ch=%0d dout=%h strobe=%b, want 2/1234/0",
                  a_ch, a_dout, a_strobe);
      else n_pass++;
      a_din = ADin;
      a_sel = 2'd0;
      tick();
   endtask

   task automatic test_scan();
      int seq [13] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
      a_scan_en = 1'b1;
      for (int i = 0; i < 13; i++) begin
         logic exp_strobe;
         tick();
         exp_strobe = (i > 0) && (seq[i] != seq[i-1]);
         n_checks++;
         if ({a_ch, a_dout, a_strobe} !== {2'(seq[i]), a_word(seq[i]), exp_strobe})
            $display("FAIL scan_seq[%0d]: ch=%0d dout=%h strobe=%b, want %0d/%h/%b",
                     i, a_ch, a_dout, a_strobe, seq[i], a_word(seq[i]), exp_strobe);
         else n_pass++;
      end
   endtask

   task automatic test_hold();
      // ch=0 with count 0 -> two more cycles on ch0, then ch1, then one cycle into ch1
      for (int i = 0; i < 4; i++) tick();
      n_checks++;
      if (a_ch !== 2'd1) $display("FAIL hold_setup: ch=%0d, want 1", a_ch);
      else n_pass++;
      a_hold = 1'b1;
      a_din[31:16] = 16'h5555;
      for (int i = 0; i < 10; i++) begin
         tick();
         n_checks++;
         if ({a_ch, a_dout, a_strobe} !== {2'd1, 16'h5555, 1'b0})
            $display("FAIL hold_frozen[%0d]: ch=%0d dout=%h strobe=%b, want 1/5555/0",
                     i, a_ch, a_dout, a_strobe);
         else n_pass++;
      end
      a_hold = 1'b0;
      a_din = ADin;
      tick();
      n_checks++;
      if ({a_ch, a_strobe} !== {2'd1, 1'b0})
         $display("FAIL hold_remaining: ch=%0d strobe=%b, want 1/0", a_ch, a_strobe);
      else n_pass++;
      tick();
      n_checks++;
      if ({a_ch, a_dout, a_strobe} !== {2'd2, 16'hCCCC, 1'b1})
         $display("FAIL hold_resume: ch=%0d dout=%h strobe=%b, want 2/cccc/1",
                  a_ch, a_dout, a_strobe);
      else n_pass++;
   endtask

   task automatic test_mode_switch();
      for (int i = 0; i < 3; i++) tick();
      n_checks++;
      if ({a_ch, a_strobe} !== {2'd3, 1'b1})
         $display("FAIL mode_setup: ch=%0d strobe=%b, want 3/1", a_ch, a_strobe);
      else n_pass++;
      a_sel = 2'd1;
      a_scan_en = 1'b0;
      tick();
      n_checks++;
      if ({a_ch, a_dout, a_strobe} !== {2'd1, 16'hBBBB, 1'b1})
         $display("FAIL mode_to_manual: ch=%0d dout=%h strobe=%b, want 1/bbbb/1",
                  a_ch, a_dout, a_strobe);
      else n_pass++;
      a_scan_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++;
         if ({a_ch, a_strobe} !== {2'd1, 1'b0})
            $display("FAIL mode_rescan_dwell[%0d]: ch=%0d strobe=%b, want 1/0",
                     i, a_ch, a_strobe);
         else n_pass++;
      end
      tick();
      n_checks++;
      if ({a_ch, a_dout, a_strobe} !== {2'd2, 16'hCCCC, 1'b1})
         $display("FAIL mode_rescan_adv: ch=%0d dout=%h strobe=%b, want 2/cccc/1",
                  a_ch, a_dout, a_strobe);
      else n_pass++;
   endtask

   task automatic test_nonpow2();
      int seq [7] = '{0, 0, 1, 1, 2, 2, 0};
      logic [7:0] bw [3] = '{8'h11, 8'h22, 8'h33};
      b_scan_en = 1'b1;
      for (int i = 0; i < 7; i++) begin
         logic exp_strobe;
         tick();
         exp_strobe = (i > 0) && (seq[i] != seq[i-1]);
         n_checks++;
         if ({b_ch, b_dout, b_strobe} !== {2'(seq[i]), bw[seq[i]], exp_strobe})
            $display("FAIL np2_scan[%0d]: ch=%0d dout=%h strobe=%b, want %0d/%h/%b",
                     i, b_ch, b_dout, b_strobe, seq[i], bw[seq[i]], exp_strobe);
         else n_pass++;
      end
      b_scan_en = 1'b0;
      b_sel = 2'd3;
      tick();
      n_checks++;
      if ({b_ch, b_dout, b_strobe} !== {2'd2, 8'h33, 1'b1})
         $display("FAIL np2_clamp: ch=%0d dout=%h strobe=%b, want 2/33/1",
                  b_ch, b_dout, b_strobe);
      else n_pass++;
      b_sel = 2'd2;
      tick();
      n_checks++;
      if ({b_ch, b_strobe} !== {2'd2, 1'b0})
         $display("FAIL np2_same: ch=%0d strobe=%b, want 2/0", b_ch, b_strobe);
      else n_pass++;
   endtask

   task automatic test_reset_wins();
      a_scan_en = 1'b1; a_sel = 2'd3; a_hold = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      n_checks++;
      if ({a_ch, a_dout, a_strobe} !== 19'd0)
         $display("FAIL reset_wins: ch=%0d dout=%h strobe=%b, want 0/0000/0",
                  a_ch, a_dout, a_strobe);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_manual();
      test_scan();
      test_hold();
      test_mode_switch();
      test_nonpow2();
      test_reset_wins();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/scan_mux.md
# scan_mux

Parametrised, registered CHANNELS-to-1 selector of WIDTH-bit words, the successor to the fixed 4:1 16-bit display-source mux. Runs in one of two modes: manual (switch-driven channel select) or auto-scan (round-robin through all channels with a programmable dwell time). Sits between the measurement/data sources and the seven-segment display driver. Flags every channel change with a one-cycle strobe.

## Interface
- WIDTH, 16, bits per channel word
- CHANNELS, 4, number of input channels (≥2, need not be a power of 2)
- DWELL, 50_000_000, clock cycles spent on each channel in scan mode (≥1)
- SW = $clog2(CHANNELS) (localparam), channel index width
- clk  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-high reset
- din  in  CHANNELS*WIDTH  flattened inputs; channel k = din[k*WIDTH +: WIDTH]
- sel  in  SW  manual channel select
- scan_en  in  1  0 = manual mode, 1 = auto-scan mode
- hold  in  1  scan mode only: freeze dwell counter and current channel
- dout  out  WIDTH  registered selected word
- ch  out  SW  registered index of the channel currently driving dout
- strobe  out  1  one-cycle pulse on the cycle ch takes a new value

## Operation
- States: MANUAL, SCAN. Reset → MANUAL, dout=0, ch=0, strobe=0, dwell count=0.
- Register update each edge: ch ← ch_next; dout ← din[ch_next] (dout and ch always consistent; dout tracks live din of the selected channel).
- MANUAL: ch_next = sel; sel ≥ CHANNELS clamps to CHANNELS-1. Dwell count held at 0. hold ignored.
- MANUAL→SCAN when scan_en=1: count cleared; scan resumes from current ch.
- SCAN: count increments each cycle unless hold=1. When count = DWELL-1 and hold=0: count←0, ch_next = (ch = CHANNELS-1) ? 0 : ch+1.
- SCAN→MANUAL when scan_en=0: ch_next = sel (clamped) on that same edge; count cleared.
- hold=1 in SCAN: count and ch frozen; dout still follows din[ch].
- strobe = 1 on the edge where ch_next ≠ ch, else 0. No strobe on reset.
- DWELL=1: channel advances every cycle (strobe continuously high).
- Reset wins over all inputs on the same edge.

## Timing
- din → dout latency 1 cycle.
- sel → ch/dout in MANUAL: 1 cycle.
- Scan period per channel: exactly DWELL cycles (excluding hold cycles); full rotation CHANNELS*DWELL cycles.
- Mode change takes effect on the first edge where scan_en is sampled at the new value.
- scan_en, sel, hold are assumed synchronised upstream (debouncer/synchroniser); no internal synchronisation.

## Structure
- Shared package scan_mux_pkg: state enum (ST_MANUAL, ST_SCAN), channel-index clamp function.
- Sub-module dwell_counter: parameter DWELL; inputs clk, reset, clr, en; output tc (terminal count, count = DWELL-1 and en). Width $clog2(DWELL) with DWELL=1 handled (tc = en).
- Top: FSM, channel register, next-channel logic, output register, strobe compare.

## Test plan
- Reset: drive reset 2 cycles with random inputs → dout=0, ch=0, strobe=0 throughout and first cycle after release.
- Manual select (CHANNELS=4, WIDTH=16): din = {16'hDDDD,16'hCCCC,16'hBBBB,16'hAAAA}, sel 0→2 → next edge ch=2, dout=16'hCCCC, strobe one cycle; din ch2 → 16'h1234 → dout=16'h1234 one cycle later.
- Auto-scan (DWELL=3): scan_en=1 from ch=0 → ch sequence 0,0,0,1,1,1,2,2,2,3,3,3,0; strobe on each change incl. wrap 3→0.
- Hold: in SCAN at ch=1 mid-dwell, hold=1 for 10 cycles → ch stays 1, no strobe; release → remaining dwell cycles then ch=2.
- Non-power-of-2 + clamp (CHANNELS=3, DWELL=2): scan wraps 2→0; manual sel=3 → ch=2.
- Mode switch: SCAN at ch=3, sel=1, drop scan_en → next edge ch=1, strobe=1; reassert scan_en → ch=1 for 3 cycles then 2.
